// File: rtl/ring_osc_pkg.sv
// Shared types and constants for the ring-oscillator measurement counter.
package ring_osc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_COUNT = 2'd2
    } state_e;

    localparam logic MODE_GATED  = 1'b0;
    localparam logic MODE_WINDOW = 1'b1;

    localparam int unsigned WIN_SEL_W  = 3;
    localparam int unsigned EDGE_CNT_W = (1 << WIN_SEL_W) - 1;

    // Value of edge_cnt on which the final reference edge of a window arrives.
    function automatic logic [EDGE_CNT_W-1:0] win_last(input logic [WIN_SEL_W-1:0] ws);
        return EDGE_CNT_W'((1 << ws) - 1);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchroniser with registered rise/fall pulses; level is aligned to the pulses.
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic count_clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q;
    logic                   fall_q;

    always_ff @(posedge count_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
            fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
        end
    end

    assign level = prev_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/ring_osc_counter.sv
// Gated / reference-windowed cycle counter with byte-multiplexed result port.
// Define RO_COUNTER_SAT_EN to saturate the counter instead of wrapping.
module ring_osc_counter
    import ring_osc_pkg::*;
#(
    parameter int unsigned WIDTH       = 24,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned BSEL_W      = 2
) (
    input  logic                 count_clk,
    input  logic                 rst_n,
    input  logic                 enable_raw,
    input  logic                 ref_raw,
    input  logic                 mode,
    input  logic [WIN_SEL_W-1:0] win_sel,
    input  logic [BSEL_W-1:0]    byte_sel,
    output logic [7:0]           result_byte,
    output logic                 valid,
    output logic                 busy,
    output logic                 ovf
);

    localparam int unsigned PAD_W = 8 << BSEL_W;

    logic en_s, en_rise, en_fall;
    logic ref_s, ref_edge, ref_fall;
    logic unused_ref;

    state_e                 state_q;
    logic                   mode_q;
    logic [WIN_SEL_W-1:0]   win_sel_q;
    logic [WIDTH-1:0]       count_q;
    logic [EDGE_CNT_W-1:0]  edge_cnt_q;
    logic [WIDTH-1:0]       result_q;
    logic                   valid_q;
    logic                   ovf_q;
    logic                   ovf_bit_q;
    logic [7:0]             result_byte_q;

    logic [WIDTH-1:0]       cnt_inc;
    logic                   cnt_max;
    logic [PAD_W-1:0]       res_pad;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_en (
        .count_clk (count_clk),
        .rst_n     (rst_n),
        .din       (enable_raw),
        .level     (en_s),
        .rise      (en_rise),
        .fall      (en_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ref (
        .count_clk (count_clk),
        .rst_n     (rst_n),
        .din       (ref_raw),
        .level     (ref_s),
        .rise      (ref_edge),
        .fall      (ref_fall)
    );

    assign unused_ref = ref_s | ref_fall;

    always_comb begin
        cnt_max = &count_q;
`ifdef RO_COUNTER_SAT_EN
        cnt_inc = cnt_max ? count_q : count_q + WIDTH'(1);
`else
        cnt_inc = count_q + WIDTH'(1);
`endif
    end

    always_ff @(posedge count_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_GATED;
            win_sel_q  <= '0;
            count_q    <= '0;
            edge_cnt_q <= '0;
            result_q   <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            ovf_bit_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (en_rise) begin
                        mode_q    <= mode;
                        win_sel_q <= win_sel;
                        valid_q   <= 1'b0;
                        ovf_bit_q <= 1'b0;
                        if (mode == MODE_WINDOW) begin
                            state_q <= ST_ARM;
                            count_q <= '0;
                        end else begin
                            state_q <= ST_COUNT;
                            count_q <= WIDTH'(1);
                        end
                    end
                end
                ST_ARM: begin
                    if (en_fall) begin
                        state_q <= ST_IDLE;
                    end else if (ref_edge) begin
                        state_q    <= ST_COUNT;
                        count_q    <= '0;
                        edge_cnt_q <= '0;
                    end
                end
                ST_COUNT: begin
                    if (mode_q == MODE_GATED) begin
                        if (en_fall) begin
                            result_q <= count_q;
                            ovf_q    <= ovf_bit_q;
                            valid_q  <= 1'b1;
                            state_q  <= ST_IDLE;
                        end else if (en_s) begin
                            count_q <= cnt_inc;
                            if (cnt_max) ovf_bit_q <= 1'b1;
                        end
                    end else if (en_fall) begin
                        // Abort beats a coincident reference edge; result is untouched.
                        state_q <= ST_IDLE;
                    end else begin
                        count_q <= cnt_inc;
                        if (cnt_max) ovf_bit_q <= 1'b1;
                        if (ref_edge) begin
                            if (edge_cnt_q == win_last(win_sel_q)) begin
                                result_q <= cnt_inc;
                                ovf_q    <= ovf_bit_q | cnt_max;
                                valid_q  <= 1'b1;
                                state_q  <= ST_IDLE;
                            end else begin
                                edge_cnt_q <= edge_cnt_q + EDGE_CNT_W'(1);
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign res_pad = PAD_W'(result_q);

    always_ff @(posedge count_clk or negedge rst_n) begin
        if (!rst_n) begin
            result_byte_q <= 8'h00;
        end else begin
            result_byte_q <= res_pad[8*byte_sel +: 8];
        end
    end

    assign result_byte = result_byte_q;
    assign valid       = valid_q;
    assign ovf         = ovf_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ring_osc_counter.sv
// Bench for ring_osc_counter: table of gated/window measurements plus abort, reset and overflow cases.
module tb_ring_osc_counter;

    localparam int unsigned W = 24;

    logic       count_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable_raw = 1'b0;
    logic       ref_raw = 1'b0;
    logic       mode = 1'b0;
    logic [2:0] win_sel = 3'd0;
    logic [1:0] byte_sel = 2'd0;
    logic [7:0] result_byte;
    logic       valid, busy, ovf;

    logic       en8 = 1'b0;
    logic       ref8 = 1'b0;
    logic       mode8 = 1'b0;
    logic [2:0] win8 = 3'd0;
    logic [1:0] bsel8 = 2'd0;
    logic [7:0] rb8;
    logic       valid8, busy8, ovf8;

    int vectors = 0;
    int miscompares = 0;

    always #5 count_clk = ~count_clk;

    ring_osc_counter #(.WIDTH(W), .SYNC_STAGES(2), .BSEL_W(2)) dut (
        .count_clk   (count_clk),
        .rst_n       (rst_n),
        .enable_raw  (enable_raw),
        .ref_raw     (ref_raw),
        .mode        (mode),
        .win_sel     (win_sel),
        .byte_sel    (byte_sel),
        .result_byte (result_byte),
        .valid       (valid),
        .busy        (busy),
        .ovf         (ovf)
    );

    ring_osc_counter #(.WIDTH(8), .SYNC_STAGES(2), .BSEL_W(2)) dut8 (
        .count_clk   (count_clk),
        .rst_n       (rst_n),
        .enable_raw  (en8),
        .ref_raw     (ref8),
        .mode        (mode8),
        .win_sel     (win8),
        .byte_sel    (bsel8),
        .result_byte (rb8),
        .valid       (valid8),
        .busy        (busy8),
        .ovf         (ovf8)
    );

    typedef struct {
        bit          win_mode;
        int          win;
        int          len;
        logic [31:0] exp_res;
        bit          exp_ovf;
    } vec_t;

    vec_t vecs[$];

    // Measurement model: gated -> cycles high; window -> period * 2^win; then clip to width.
    function automatic void model(input int width, input bit m, input int w, input int len,
                                  output logic [31:0] res, output bit o);
        longint raw;
        longint maxv;
        raw  = m ? (longint'(len) << w) : longint'(len);
        maxv = (longint'(1) << width) - 1;
        o    = raw > maxv;
`ifdef RO_COUNTER_SAT_EN
        res  = o ? maxv[31:0] : raw[31:0];
`else
        res  = raw[31:0] & maxv[31:0];
`endif
    endfunction

    function automatic vec_t mk(input bit m, input int w, input int len);
        vec_t v;
        v.win_mode = m;
        v.win      = w;
        v.len      = len;
        model(W, m, w, len, v.exp_res, v.exp_ovf);
        return v;
    endfunction

    task automatic tick();
        @(posedge count_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic read_result(output logic [31:0] r);
        r = '0;
        for (int b = 0; b < 4; b++) begin
            byte_sel = b[1:0];
            tick();
            r[8*b +: 8] = result_byte;
        end
        byte_sel = 2'd0;
        tick();
    endtask

    task automatic run_gated(input int n, output bit ok);
        bit saw;
        mode       = 1'b0;
        enable_raw = 1'b1;
        repeat (n) tick();
        enable_raw = 1'b0;
        saw = busy;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (busy) saw = 1'b1;
            else if (saw) break;
        end
        ok = saw && !busy && valid;
    endtask

    task automatic run_window(input int w, input int p, output bit ok);
        bit saw;
        int budget;
        mode       = 1'b1;
        win_sel    = w[2:0];
        ref_raw    = 1'b0;
        enable_raw = 1'b1;
        repeat (6) tick();
        saw    = busy;
        budget = p * ((1 << w) + 3) + 20;
        for (int c = 0; c < budget; c++) begin
            ref_raw = (c % p) >= (p / 2);
            tick();
            if (busy) saw = 1'b1;
            else if (saw) break;
        end
        ok = saw && !busy && valid;
        ref_raw    = 1'b0;
        enable_raw = 1'b0;
        repeat (6) tick();
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit          ok;
        logic [31:0] r;
        logic [31:0] last_exp;
        logic [31:0] e8;
        bit          o8;
        int          c8;

        vecs.push_back(mk(1'b0, 0, 300));
        vecs.push_back(mk(1'b0, 0, 1));
        vecs.push_back(mk(1'b1, 2, 50));
        vecs.push_back(mk(1'b1, 0, 10));
        vecs.push_back(mk(1'b1, 3, 7));
        for (int i = 0; i < 8; i++) vecs.push_back(mk(1'b0, 0, $urandom_range(2, 400)));
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk(1'b1, $urandom_range(0, 4), $urandom_range(4, 40)));

        // Reset state
        repeat (3) tick();
        check("rst_result_byte", result_byte, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", busy, 1'b0);

        foreach (vecs[i]) begin
            if (vecs[i].win_mode) run_window(vecs[i].win, vecs[i].len, ok);
            else begin
                run_gated(vecs[i].len, ok);
                repeat (2) tick();
            end
            check($sformatf("v%0d_done", i), ok, 1'b1);
            check($sformatf("v%0d_valid", i), valid, 1'b1);
            check($sformatf("v%0d_ovf", i), ovf, vecs[i].exp_ovf);
            read_result(r);
            check($sformatf("v%0d_result", i), r, vecs[i].exp_res);
            check($sformatf("v%0d_busy", i), busy, 1'b0);
        end
        last_exp = vecs[vecs.size()-1].exp_res;

        // Abort in ARM
        mode = 1'b1; win_sel = 3'd2; enable_raw = 1'b1;
        repeat (8) tick();
        check("armabort_busy_before", busy, 1'b1);
        check("armabort_valid_cleared", valid, 1'b0);
        enable_raw = 1'b0;
        repeat (6) tick();
        check("armabort_busy", busy, 1'b0);
        check("armabort_valid", valid, 1'b0);
        read_result(r);
        check("armabort_result", r, last_exp);

        // Abort mid-COUNT (two of four window edges seen)
        mode = 1'b1; win_sel = 3'd2; enable_raw = 1'b1;
        repeat (6) tick();
        for (int c = 0; c < 35; c++) begin
            ref_raw = (c % 10) >= 5;
            tick();
        end
        check("cntabort_busy_before", busy, 1'b1);
        enable_raw = 1'b0; ref_raw = 1'b0;
        repeat (6) tick();
        check("cntabort_busy", busy, 1'b0);
        check("cntabort_valid", valid, 1'b0);
        read_result(r);
        check("cntabort_result", r, last_exp);

        // Final window edge coincides with enable drop
        mode = 1'b1; win_sel = 3'd1; enable_raw = 1'b1;
        repeat (6) tick();
        for (int c = 0; c < 25; c++) begin
            ref_raw = (c % 10) >= 5;
            tick();
        end
        check("simul_busy_before", busy, 1'b1);
        ref_raw = 1'b1; enable_raw = 1'b0;
        repeat (4) tick();
        ref_raw = 1'b0;
        repeat (4) tick();
        check("simul_valid", valid, 1'b0);
        check("simul_busy", busy, 1'b0);
        read_result(r);
        check("simul_result", r, last_exp);

        // Reset mid-COUNT while an earlier result is still readable
        run_gated(300, ok);
        repeat (2) tick();
        check("pre_rst_done", ok, 1'b1);
        mode = 1'b0; enable_raw = 1'b1; byte_sel = 2'd0;
        repeat (20) tick();
        check("midrst_busy_before", busy, 1'b1);
        check("midrst_old_byte", result_byte, 8'h2C);
        rst_n = 1'b0;
        #1;
        check("midrst_result_byte", result_byte, 8'h00);
        check("midrst_valid", valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ovf", ovf, 1'b0);
        enable_raw = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // 8-bit counter run past its range
        model(8, 1'b0, 0, 300, e8, o8);
        en8 = 1'b1;
        repeat (300) tick();
        en8 = 1'b0;
        c8 = 0;
        while (!valid8 && c8 < 20) begin
            tick();
            c8++;
        end
        check("ovf8_done", valid8, 1'b1);
        tick();
        check("ovf8_result", rb8, e8[7:0]);
        check("ovf8_flag", ovf8, o8);
        check("ovf8_busy", busy8, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
